// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter family.
// Direction/mode encodings and the per-edge action type.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int MODE_SAT  = 0;
    localparam int MODE_WRAP = 1;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_STEP
    } act_e;

endpackage

// File: rtl/counter_next.sv
// Next-state and terminal-count logic for the modulo counter.
// Purely combinational; the top only registers its outputs.
module counter_next
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16,
    parameter int     WRAP    = MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             ovf,
    input  logic             en,
    input  logic             ci,
    input  logic             up,
    input  logic             ld,
    output logic [WIDTH-1:0] q_nxt,
    output logic             ovf_nxt,
    output logic             at_term
);

    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
    localparam logic [63:0]      MOD64   = 64'(MODULUS);
    localparam bit               IS_WRAP = (WRAP == MODE_WRAP);

    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] inc_q;
    logic [WIDTH-1:0] dec_q;
    logic [WIDTH-1:0] ld_q;
    act_e             act;

    always_comb begin
        at_top  = (q == TOP);
        at_bot  = (q == '0);
        at_term = (up == DIR_UP) ? at_top : at_bot;
    end

    // Terminal cases override the raw +/-1 so no intermediate overflow.
    always_comb begin
        inc_q = q + WIDTH'(1);
        if (at_top) inc_q = IS_WRAP ? '0 : TOP;
        dec_q = q - WIDTH'(1);
        if (at_bot) dec_q = IS_WRAP ? TOP : '0;
        ld_q = (64'(d) >= MOD64) ? TOP : d;
    end

    always_comb begin
        act = ACT_HOLD;
        if (ld) begin
            act = ACT_LOAD;
        end else if (en & ci) begin
            act = ACT_STEP;
        end
    end

    always_comb begin
        q_nxt   = q;
        ovf_nxt = ovf;
        unique case (act)
            ACT_LOAD: begin
                q_nxt   = ld_q;
                ovf_nxt = 1'b0;
            end
            ACT_STEP: begin
                q_nxt   = (up == DIR_UP) ? inc_q : dec_q;
                ovf_nxt = ovf | at_term;
            end
            default: begin
                q_nxt   = q;
                ovf_nxt = ovf;
            end
        endcase
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Cascadable up/down modulo counter with load, wrap/saturate and sticky ovf.
// Holds only the q/ovf registers, reset handling and rc gating.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16,
    parameter int     WRAP    = MODE_WRAP
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ci,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rc,
    output logic             ovf
);

    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;
    logic             at_term;

    counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .WRAP    (WRAP)
    ) u_next (
        .q       (q),
        .d       (d),
        .ovf     (ovf),
        .en      (en),
        .ci      (ci),
        .up      (up),
        .ld      (ld),
        .q_nxt   (q_nxt),
        .ovf_nxt (ovf_nxt),
        .at_term (at_term)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= q_nxt;
            ovf <= ovf_nxt;
        end
    end

    // rst_n gating keeps rc low while q is held at 0 in reset.
    assign rc = rst_n & en & ci & at_term;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: wrap, saturate and two-stage cascade instances
// compared every cycle against a spec-level model plus literal checks.
module tb_mod_updown_counter;

    logic       ck = 1'b0;
    logic       rst_n;
    logic       en;
    logic       ci;
    logic       up;
    logic       ld;
    logic [3:0] d;
    logic       enc;
    logic       upc;
    logic       one = 1'b1;
    logic       zero = 1'b0;
    logic [3:0] dz = 4'd0;

    logic [3:0] q_w, q_s, q_lo, q_hi;
    logic       rc_w, rc_s, rc_lo, rc_hi;
    logic       ovf_w, ovf_s, ovf_lo, ovf_hi;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_on = 1'b0;

    int mw = 0;
    int ms = 0;
    int mc = 0;
    bit mow = 1'b0;
    bit mos = 1'b0;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1)) u_wrap (
        .ck(ck), .rst_n(rst_n), .en(en), .ci(ci), .up(up), .ld(ld),
        .d(d), .q(q_w), .rc(rc_w), .ovf(ovf_w)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(0)) u_sat (
        .ck(ck), .rst_n(rst_n), .en(en), .ci(ci), .up(up), .ld(ld),
        .d(d), .q(q_s), .rc(rc_s), .ovf(ovf_s)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1)) u_lo (
        .ck(ck), .rst_n(rst_n), .en(enc), .ci(one), .up(upc), .ld(zero),
        .d(dz), .q(q_lo), .rc(rc_lo), .ovf(ovf_lo)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1)) u_hi (
        .ck(ck), .rst_n(rst_n), .en(enc), .ci(rc_lo), .up(upc), .ld(zero),
        .d(dz), .q(q_hi), .rc(rc_hi), .ovf(ovf_hi)
    );

    initial forever #5 ck = ~ck;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int nxt(input int v, input bit dir, input bit wrap);
        if (wrap) return dir ? (v + 1) % 10 : (v + 9) % 10;
        if (dir) return (v < 9) ? v + 1 : 9;
        return (v > 0) ? v - 1 : 0;
    endfunction

    function automatic bit term(input int v, input bit dir);
        return dir ? (v == 9) : (v == 0);
    endfunction

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            mw <= 0; ms <= 0; mc <= 0;
            mow <= 1'b0; mos <= 1'b0;
        end else begin
            if (ld) begin
                mw  <= (d >= 4'd10) ? 9 : int'(d);
                ms  <= (d >= 4'd10) ? 9 : int'(d);
                mow <= 1'b0;
                mos <= 1'b0;
            end else if (en && ci) begin
                mw  <= nxt(mw, up, 1'b1);
                mow <= mow | term(mw, up);
                ms  <= nxt(ms, up, 1'b0);
                mos <= mos | term(ms, up);
            end
            if (enc) mc <= upc ? (mc + 1) % 100 : (mc + 99) % 100;
        end
    end

    always @(negedge ck) begin
        if (chk_on) begin
            #1;
            chk("w_q", q_w, mw);
            chk("w_ovf", ovf_w, mow);
            chk("w_rc", rc_w, rst_n & en & ci & term(mw, up));
            chk("s_q", q_s, ms);
            chk("s_ovf", ovf_s, mos);
            chk("s_rc", rc_s, rst_n & en & ci & term(ms, up));
            chk("c_val", q_hi * 10 + q_lo, mc);
        end
    end

    task automatic tick();
        @(posedge ck);
        @(negedge ck);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; ci = 1'b1; up = 1'b1;
        ld = 1'b0; d = 4'd0; enc = 1'b0; upc = 1'b1;
        chk_on = 1'b1;
        tick();
        tick();
        chk("rst_q", q_w, 0);
        chk("rst_ovf", ovf_w, 0);
        chk("rst_rc", rc_w, 0);

        rst_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("up_q", q_w, (i + 1) % 10);
            chk("up_rc", rc_w, ((i + 1) % 10) == 9);
            chk("up_ovf", ovf_w, i >= 9);
        end
        chk("up_sat_q", q_s, 9);
        chk("up_sat_ovf", ovf_s, 1);

        ld = 1'b1; d = 4'd0;
        tick();
        ld = 1'b0; up = 1'b0;
        #1;
        chk("dn_rc0", rc_w, 1);
        chk("dn_ovf0", ovf_w, 0);
        tick();
        chk("dn_q9", q_w, 9);
        chk("dn_ovf1", ovf_w, 1);
        tick();
        chk("dn_q8", q_w, 8);

        ld = 1'b1; d = 4'd8;
        tick();
        chk("sat_q8", q_s, 8);
        chk("sat_ovf8", ovf_s, 0);
        ld = 1'b0; up = 1'b1;
        tick();
        chk("sat_q9a", q_s, 9);
        chk("sat_ovf9a", ovf_s, 0);
        tick();
        chk("sat_q9b", q_s, 9);
        chk("sat_ovf9b", ovf_s, 1);
        tick();
        chk("sat_q9c", q_s, 9);
        ld = 1'b1; d = 4'd3;
        tick();
        chk("sat_ld3", q_s, 3);
        chk("sat_ld3_ovf", ovf_s, 0);

        d = 4'd12;
        tick();
        chk("ld12_w", q_w, 9);
        chk("ld12_s", q_s, 9);
        en = 1'b0; d = 4'd4;
        tick();
        chk("ld_en0", q_w, 4);
        d = 4'd9;
        tick();
        ld = 1'b0; en = 1'b1; ci = 1'b0;
        #1;
        chk("ci0_rc", rc_w, 0);
        tick();
        chk("ci0_hold", q_w, 9);
        ci = 1'b1;
        #1;
        chk("dir_rc_up", rc_w, 1);
        up = 1'b0;
        #1;
        chk("dir_rc_dn", rc_w, 0);
        chk("dir_q", q_w, 9);

        up = 1'b1;
        tick();
        chk("wrap_ovf", ovf_w, 1);
        repeat (5) tick();
        chk("at5", q_w, 5);
        up = 1'b0;
        #1;
        rst_n = 1'b0;
        ld = 1'b1; d = 4'd7;
        #1;
        chk("arst_q", q_w, 0);
        chk("arst_ovf", ovf_w, 0);
        chk("arst_rc", rc_w, 0);
        tick();
        chk("arst_hold", q_w, 0);
        rst_n = 1'b1; ld = 1'b0; up = 1'b1;
        tick();
        chk("arst_resume", q_w, 1);

        en = 1'b0; enc = 1'b1; upc = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("cas_up", q_hi * 10 + q_lo, (i + 1) % 100);
        end
        upc = 1'b0;
        tick();
        chk("cas_dn", q_hi * 10 + q_lo, 99);
        upc = 1'b1;
        tick();
        chk("cas_up0", q_hi * 10 + q_lo, 0);
        enc = 1'b0;
        tick();

        chk_on = 1'b0;
        #3;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
